// File: rtl/mult_pkg.sv
// Shared definitions for the digit-serial multiplier family.
// It holds the FSM state encoding and the digit-count helper that sibling multipliers reuse.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Operands are consumed as base-4 digits, two bits at a time.
    localparam int DIGIT_W = 2;

    // Number of base-4 digits in one operand of the given bit width.
    function automatic int num_digits(input int width);
        return width / DIGIT_W;
    endfunction

endpackage

// File: rtl/mult2_2.sv
// 2x2 unsigned gate-level multiplier that returns a 4-bit product.
module mult2_2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);

    logic pp_10;
    logic pp_01;
    logic pp_11;
    logic carry1;

    assign pp_10  = a[1] & b[0];
    assign pp_01  = a[0] & b[1];
    assign pp_11  = a[1] & b[1];
    assign carry1 = pp_10 & pp_01;

    assign p[0] = a[0] & b[0];
    assign p[1] = pp_10 ^ pp_01;
    assign p[2] = pp_11 ^ carry1;
    assign p[3] = pp_11 & carry1;

endmodule

// File: rtl/mult8_seq.sv
// Sequential unsigned multiplier built on base-4 digits.
// In RUN it spends one cycle on each digit pair (a_i, b_j), so a product takes D*D RUN cycles.
// Each digit product comes from a single shared 2x2 multiplier and is accumulated
// at bit weight 2*(i+j).
//
// state | meaning
// IDLE  | waiting for start; operands are captured on the accepting edge
// RUN   | one digit pair per cycle is accumulated; busy=1
// DONE  | out holds the new product; done=1 for this single cycle
module mult8_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] out
);

    localparam int D  = num_digits(WIDTH);
    localparam int IW = $clog2(D);
    localparam int PW = 2 * WIDTH;

    if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
        $error("mult8_seq: WIDTH must be even and at least 4");
    end

    mult_state_t       state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     out_q, out_d;
    logic [IW-1:0]     i_q, i_d;
    logic [IW-1:0]     j_q, j_d;

    logic [DIGIT_W-1:0] digit_a;
    logic [DIGIT_W-1:0] digit_b;
    logic [3:0]         digit_prod;
    logic [PW-1:0]      term;
    logic               j_last;
    logic               i_last;

    assign digit_a = a_q[DIGIT_W*i_q +: DIGIT_W];
    assign digit_b = b_q[DIGIT_W*j_q +: DIGIT_W];

    mult2_2 u_digit_mult (
        .a (digit_a),
        .b (digit_b),
        .p (digit_prod)
    );

    // The largest partial sum is still below 2^PW, so the accumulator cannot overflow.
    assign term   = PW'(digit_prod) << (DIGIT_W * (int'(i_q) + int'(j_q)));
    assign j_last = (j_q == IW'(D - 1));
    assign i_last = (i_q == IW'(D - 1));

    // Next-state logic: operand capture, the digit-pair walk and result publication.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        out_d   = out_q;
        i_d     = i_q;
        j_d     = j_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = in1;
                    b_d     = in2;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_q + term;
                if (j_last) begin
                    j_d = '0;
                    i_d = i_last ? '0 : i_q + 1'b1;
                end else begin
                    j_d = j_q + 1'b1;
                end
                // Publish on the final pair, including that pair's own contribution.
                if (j_last && i_last) begin
                    out_d   = acc_q + term;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset clears the whole datapath at once, without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign out  = out_q;

endmodule

// File: tb/tb_mult8_seq.sv
// Directed and random bench for mult8_seq at WIDTH=8.
module tb_mult8_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  in1;
    logic [7:0]  in2;
    logic        busy;
    logic        done;
    logic [15:0] out;

    int checks   = 0;
    int failures = 0;

    mult8_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts one operation from IDLE and returns the result, the latency and the busy-cycle count.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output logic [15:0] res, output int lat,
                          output int busy_cyc, output bit ok);
        int guard;
        ok = 1'b0; lat = 0; busy_cyc = 0; res = '0; guard = 0;
        while ((busy || done) && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        in1 = a; in2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; lat = 1;
        if (busy) busy_cyc++;
        while (!done && lat < 40) begin
            @(posedge clk); #1; lat++;
            if (busy) busy_cyc++;
        end
        if (done) begin
            ok  = 1'b1;
            res = out;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0;
        #1;
        checks++;
        if (out !== 16'h0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: out=%0h busy=%b done=%b, expected out=0 busy=0 done=0", out, busy, done);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_max();
        logic [15:0] res; int lat; int bc; bit ok;
        run_op(8'd255, 8'd255, res, lat, bc, ok);
        checks++;
        if (!ok || res !== 16'hFE01) begin
            failures++;
            $display("FAIL max_product: ok=%0d out=%0h, expected FE01", ok, res);
        end
        checks++;
        if (lat !== 17) begin
            failures++;
            $display("FAIL max_latency: got %0d cycles, expected 17", lat);
        end
        checks++;
        if (bc !== 16) begin
            failures++;
            $display("FAIL max_busy_cycles: got %0d, expected 16", bc);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL done_one_cycle: done=%b busy=%b, expected 0/0", done, busy);
        end
    endtask

    task automatic test_vectors();
        logic [7:0]  va [3] = '{8'd171, 8'd170, 8'd0};
        logic [7:0]  vb [3] = '{8'd205, 8'd85, 8'd200};
        logic [15:0] ve [3] = '{16'h88EF, 16'h3872, 16'h0000};
        logic [15:0] res; int lat; int bc; bit ok;
        for (int k = 0; k < 3; k++) begin
            run_op(va[k], vb[k], res, lat, bc, ok);
            checks++;
            if (!ok || res !== ve[k]) begin
                failures++;
                $display("FAIL vector_%0d: %0d*%0d ok=%0d out=%0h, expected %0h", k, va[k], vb[k], ok, res, ve[k]);
            end
        end
    endtask

    task automatic test_operand_change();
        int lat;
        bit out_moved;
        int extra_busy;
        @(posedge clk); #1;
        in1 = 8'd171; in2 = 8'd205; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        out_moved = 1'b0; lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk); #1; lat++;
            if (lat == 5) begin
                in1 = 8'd1; in2 = 8'd1; start = 1'b1;
            end else if (lat == 6) begin
                start = 1'b0;
            end
            if (busy && out !== 16'h0000) out_moved = 1'b1;
        end
        checks++;
        if (out_moved) begin
            failures++;
            $display("FAIL out_hold_in_run: out changed during RUN, expected previous value 0");
        end
        checks++;
        if (!done || out !== 16'h88EF) begin
            failures++;
            $display("FAIL operand_change: done=%b out=%0h, expected 88EF", done, out);
        end
        extra_busy = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (busy || done) extra_busy++;
        end
        checks++;
        if (extra_busy !== 0) begin
            failures++;
            $display("FAIL no_second_op: busy/done seen %0d cycles, expected 0", extra_busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int spurious;
        logic [15:0] res; int lat; int bc; bit ok;
        in1 = 8'd200; in2 = 8'd150; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out !== 16'h0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: out=%0h busy=%b done=%b, expected 0/0/0", out, busy, done);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        spurious = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done || busy) spurious++;
        end
        checks++;
        if (spurious !== 0) begin
            failures++;
            $display("FAIL no_done_after_reset: activity on %0d cycles, expected 0", spurious);
        end
        run_op(8'd3, 8'd7, res, lat, bc, ok);
        checks++;
        if (!ok || res !== 16'd21 || lat !== 17) begin
            failures++;
            $display("FAIL post_reset_op: ok=%0d out=%0d lat=%0d, expected 21 with latency 17", ok, res, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ba [4] = '{8'd12, 8'd255, 8'd99, 8'd7};
        logic [7:0]  bb [4] = '{8'd34, 8'd2, 8'd101, 8'd0};
        logic [15:0] be [4] = '{16'd408, 16'd510, 16'd9999, 16'd0};
        int k; int cyc; int prev;
        k = 0; cyc = 0; prev = 0;
        in1 = ba[0]; in2 = bb[0]; start = 1'b1;
        while (k < 4 && cyc < 120) begin
            @(posedge clk); #1; cyc++;
            if (done) begin
                checks++;
                if (out !== be[k]) begin
                    failures++;
                    $display("FAIL b2b_product_%0d: out=%0d, expected %0d", k, out, be[k]);
                end
                if (k > 0) begin
                    checks++;
                    if (cyc - prev !== 18) begin
                        failures++;
                        $display("FAIL b2b_interval_%0d: %0d cycles, expected 18", k, cyc - prev);
                    end
                end
                prev = cyc;
                k++;
                if (k < 4) begin
                    in1 = ba[k]; in2 = bb[k];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (k !== 4) begin
            failures++;
            $display("FAIL b2b_count: %0d results, expected 4", k);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random_sweep();
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] expv;
        logic [15:0] res; int lat; int bc; bit ok;
        int errs;
        errs = 0;
        for (int n = 0; n < 1000; n++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            expv = 16'(a) * 16'(b);
            run_op(a, b, res, lat, bc, ok);
            checks++;
            if (!ok || res !== expv) begin
                failures++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_%0d: %0d*%0d ok=%0d out=%0d, expected %0d", n, a, b, ok, res, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_max();
        test_vectors();
        test_operand_change();
        test_reset_mid_run();
        test_back_to_back();
        test_random_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult8_seq.md
MULT8_SEQ -- requirements
Module: mult8_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the operand width; legal values are even and at least 4.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin one multiplication.
REQ-005 The block SHALL have ports in1 and in2, each input, WIDTH bits, unsigned operands sampled with start.
REQ-006 The block SHALL have port busy, output, 1 bit, high while in RUN.
REQ-007 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking a valid result.
REQ-008 The block SHALL have port out, output, 2*WIDTH bits, the unsigned product.

Function
REQ-009 The block SHALL compute out = in1*in2 (unsigned, full 2*WIDTH-bit width) by iterating 2-bit digit pairs.
REQ-010 The block SHALL use D = WIDTH/2 digits per operand: digit a_i = in1[2i+1:2i] and digit b_j = in2[2j+1:2j].
REQ-011 The FSM SHALL have exactly three states, IDLE, RUN and DONE, and reset into IDLE.
REQ-012 On a clk edge in IDLE with start=1, the block SHALL register in1 and in2, clear the accumulator, set i=j=0 and enter RUN.
REQ-013 On a clk edge in IDLE with start=0, the block SHALL stay in IDLE.
REQ-014 On each RUN edge, the block SHALL add the 4-bit product a_i*b_j, shifted left by 2*(i+j), into a 2*WIDTH-bit accumulator with no overflow possible.
REQ-015 After each RUN edge, j SHALL increment; when j wraps from D-1 to 0, i SHALL increment.
REQ-016 The RUN edge that processes i=j=D-1 SHALL move the FSM to DONE, so RUN lasts exactly D*D cycles (16 cycles at WIDTH=8).
REQ-017 On entry to DONE, out SHALL load the accumulator and done SHALL be high for exactly one cycle.
REQ-018 The FSM SHALL return from DONE to IDLE on the next edge, unconditionally.
REQ-019 The start-to-done latency SHALL be D*D+1 cycles, counted from the edge that samples start to the first cycle with done=1 (17 cycles at WIDTH=8).
REQ-020 out SHALL hold its value until the next DONE; it SHALL NOT change during RUN.
REQ-021 start SHALL be ignored in RUN and DONE; registered operands SHALL be unaffected by in1/in2 changes after acceptance.
REQ-022 busy SHALL equal (state==RUN); done SHALL equal (state==DONE).
REQ-023 The maximum throughput SHALL be one result per D*D+2 cycles, with start held high continuously.

Reset
REQ-024 While rst is high, the FSM SHALL be in IDLE and out, the accumulator, the operand registers, i and j SHALL be 0, with busy=0 and done=0; this applies immediately, without a clock.
REQ-025 If rst asserts during RUN or DONE, the in-flight operation SHALL be discarded and no done pulse SHALL be produced for it.
REQ-026 After rst deasserts, the first start SHALL be accepted on the first clk edge in IDLE.

Structure
REQ-027 The digit product SHALL be produced by one instance of the existing 2x2 gate-level multiplier mult2_2, which receives a_i and b_j and returns a 4-bit product.
REQ-028 No other sub-module is required.
REQ-029 The state encoding (IDLE, RUN, DONE) and the derived constant D SHALL be placed in a shared package, mult_pkg, for reuse by sibling multipliers.

Verification
REQ-030 At WIDTH=8, the bench SHALL drive start with in1=255 and in2=255; out SHALL be 65025 (0xFE01) with done 17 cycles after start and busy high for 16 cycles.
REQ-031 The bench SHALL run operand pairs 171*205 -> 35055 (0x88EF), 170*85 -> 14450 (0x3872) and 0*200 -> 0, each checked at the done pulse.
REQ-032 The bench SHALL change in1/in2 and pulse start during RUN; the result SHALL match the originally accepted operands, and no second operation SHALL start.
REQ-033 The bench SHALL assert rst at cycle 8 of RUN; outputs SHALL go to 0 asynchronously, no done SHALL appear, and a following 3*7 operation SHALL return 21.
REQ-034 The bench SHALL hold start high with varying operands; done SHALL pulse every 18 cycles with correct products.
REQ-035 The bench SHALL run a random sweep of 1000 operand pairs against a reference model, with zero mismatches.
